// File: rtl/led_pkg.sv
// Shared mode encodings and sizing helpers for the LED sequencer.
// Latency: n/a. Backpressure: n/a.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_UP       = 2'b00,
        MODE_DOWN     = 2'b01,
        MODE_PINGPONG = 2'b10,
        MODE_FREEZE   = 2'b11
    } led_mode_t;

    // Rate counter width; a RATE of 1 still gets a 1-bit counter.
    function automatic int cnt_width(input int rate);
        return (rate > 1) ? $clog2(rate) : 1;
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Button synchroniser: SYNC_STAGES-deep flop chain, reset to 0.
// Latency: SYNC_STAGES clocks. Backpressure: none.
module btn_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic button_i,
    output logic btn_s_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], button_i};
        end
    end

    assign btn_s_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/led_sequencer.sv
// LED colour sequencer: steps colour through [MIN_CODE..MAX_CODE] while the button is held.
// Latency: first step SYNC_STAGES-1+RATE edges after press, then every RATE edges.
// Backpressure: none; release freezes colour and discards the partial count.
module led_sequencer
    import led_pkg::*;
#(
    parameter int WIDTH       = 3,
    parameter int MIN_CODE    = 1,
    parameter int MAX_CODE    = 6,
    parameter int RATE        = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             button,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] colour,
    output logic             dir,
    output logic             wrap
);

    localparam int             CW       = cnt_width(RATE);
    localparam logic [CW-1:0]  CNT_LAST = CW'(RATE - 1);
    localparam logic [WIDTH-1:0] MIN_C  = WIDTH'(MIN_CODE);
    localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX_CODE);

    generate
        if (!(MIN_CODE < MAX_CODE && MAX_CODE <= (2**WIDTH) - 1)) begin : g_bad_range
            $error("led_sequencer: need MIN_CODE < MAX_CODE <= 2**WIDTH-1");
        end
        if (RATE < 1 || SYNC_STAGES < 2) begin : g_bad_timing
            $error("led_sequencer: need RATE >= 1 and SYNC_STAGES >= 2");
        end
    endgenerate

    logic             btn_s;
    led_mode_t        mode_e;
    logic             step;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [WIDTH-1:0] colour_q, colour_d;
    logic             dir_q,    dir_d;
    logic             wrap_q,   wrap_d;

    assign mode_e = led_mode_t'(mode);

    btn_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_btn_sync (
        .clk      (clk),
        .rst      (rst),
        .button_i (button),
        .btn_s_o  (btn_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            colour_q <= MIN_C;
            dir_q    <= 1'b1;
            wrap_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            colour_q <= colour_d;
            dir_q    <= dir_d;
            wrap_q   <= wrap_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        step  = 1'b0;
        if (!btn_s || mode_e == MODE_FREEZE) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = '0;
            step  = 1'b1;
        end
    end

    // Out-of-range recovery wins over stepping; bounds are explicit, never modulo.
    always_comb begin
        colour_d = colour_q;
        dir_d    = dir_q;
        wrap_d   = 1'b0;
        if (colour_q < MIN_C || colour_q > MAX_C) begin
            colour_d = MIN_C;
        end else if (step) begin
            case (mode_e)
                MODE_UP: begin
                    if (colour_q == MAX_C) begin
                        colour_d = MIN_C;
                        wrap_d   = 1'b1;
                    end else begin
                        colour_d = colour_q + WIDTH'(1);
                    end
                end
                MODE_DOWN: begin
                    if (colour_q == MIN_C) begin
                        colour_d = MAX_C;
                        wrap_d   = 1'b1;
                    end else begin
                        colour_d = colour_q - WIDTH'(1);
                    end
                end
                MODE_PINGPONG: begin
                    if (dir_q && colour_q == MAX_C) begin
                        colour_d = colour_q - WIDTH'(1);
                        dir_d    = 1'b0;
                        wrap_d   = 1'b1;
                    end else if (!dir_q && colour_q == MIN_C) begin
                        colour_d = colour_q + WIDTH'(1);
                        dir_d    = 1'b1;
                        wrap_d   = 1'b1;
                    end else if (dir_q) begin
                        colour_d = colour_q + WIDTH'(1);
                    end else begin
                        colour_d = colour_q - WIDTH'(1);
                    end
                end
                default: begin
                    colour_d = colour_q;
                end
            endcase
        end
    end

    always_comb begin
        colour = colour_q;
        dir    = dir_q;
        wrap   = wrap_q;
    end

endmodule

// File: tb/tb_led_sequencer.sv
module tb_led_sequencer;

    logic       clk;
    logic       rst;
    logic       button;
    logic [1:0] mode;
    logic [2:0] colour;
    logic       dir;
    logic       wrap;

    logic       rst1;
    logic       button1;
    logic [1:0] mode1;
    logic [2:0] colour1;
    logic       dir1;
    logic       wrap1;

    int n_cmp;
    int n_bad;
    int edge_n;

    led_sequencer #(
        .WIDTH(3), .MIN_CODE(1), .MAX_CODE(6), .RATE(4), .SYNC_STAGES(2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .button (button),
        .mode   (mode),
        .colour (colour),
        .dir    (dir),
        .wrap   (wrap)
    );

    led_sequencer #(
        .WIDTH(3), .MIN_CODE(1), .MAX_CODE(6), .RATE(1), .SYNC_STAGES(2)
    ) dut_r1 (
        .clk    (clk),
        .rst    (rst1),
        .button (button1),
        .mode   (mode1),
        .colour (colour1),
        .dir    (dir1),
        .wrap   (wrap1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic run_to(input int e);
        while (edge_n < e) tick();
    endtask

    // Leaves rst released just after an edge, so the following edge is edge 0.
    task automatic do_reset();
        rst    = 1'b1;
        button = 1'b0;
        tick();
        tick();
        rst    = 1'b0;
        edge_n = -1;
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        edge_n  = -1;
        rst     = 1'b1;
        button  = 1'b0;
        mode    = 2'b00;
        rst1    = 1'b1;
        button1 = 1'b0;
        mode1   = 2'b00;

        // 1: reset values, held and after release, then idle
        #1;
        chk("rst_colour_async", colour, 1);
        chk("rst_dir_async", dir, 1);
        chk("rst_wrap_async", wrap, 0);
        chk("r1_rst_colour", colour1, 1);
        tick(); tick(); tick();
        chk("rst_colour_held", colour, 1);
        rst  = 1'b0;
        rst1 = 1'b0;
        tick();
        chk("rel_colour", colour, 1);
        chk("rel_dir", dir, 1);
        repeat (20) tick();
        chk("idle_colour", colour, 1);
        chk("idle_wrap", wrap, 0);

        // 2: up-wrap held, first step at edge 5, then every 4 edges
        do_reset();
        mode   = 2'b00;
        button = 1'b1;
        run_to(4);  chk("up_e4_nostep", colour, 1);
        run_to(5);  chk("up_e5_first", colour, 2);
        run_to(8);  chk("up_e8", colour, 2);
        run_to(9);  chk("up_e9", colour, 3);
        run_to(21); chk("up_e21", colour, 6);
        run_to(24); chk("up_e24_wrap", wrap, 0);
        run_to(25); chk("up_e25_col", colour, 1);
                    chk("up_e25_wrap", wrap, 1);
        run_to(26); chk("up_e26_wrap", wrap, 0);
                    chk("up_dir_hold", dir, 1);
        run_to(29); chk("up_e29", colour, 2);
        button = 1'b0;
        repeat (8) tick();
        chk("up_release_hold", colour, 2);

        // 3: short holds never complete a count
        do_reset();
        mode   = 2'b00;
        button = 1'b1; repeat (3) tick();
        button = 1'b0; repeat (5) tick();
        button = 1'b1; repeat (3) tick();
        button = 1'b0; repeat (5) tick();
        chk("short_hold", colour, 1);
        button = 1'b1; repeat (4) tick();
        button = 1'b0; repeat (5) tick();
        chk("four_hold", colour, 2);

        // 4: ping-pong turns at both ends
        do_reset();
        mode   = 2'b10;
        button = 1'b1;
        run_to(21); chk("pp_e21_col", colour, 6);
                    chk("pp_e21_dir", dir, 1);
                    chk("pp_e21_wrap", wrap, 0);
        run_to(25); chk("pp_e25_col", colour, 5);
                    chk("pp_e25_dir", dir, 0);
                    chk("pp_e25_wrap", wrap, 1);
        run_to(26); chk("pp_e26_wrap", wrap, 0);
        run_to(33); chk("pp_e33_col", colour, 3);
        run_to(41); chk("pp_e41_col", colour, 1);
                    chk("pp_e41_dir", dir, 0);
                    chk("pp_e41_wrap", wrap, 0);
        run_to(45); chk("pp_e45_col", colour, 2);
                    chk("pp_e45_dir", dir, 1);
                    chk("pp_e45_wrap", wrap, 1);
        run_to(46); chk("pp_e46_wrap", wrap, 0);

        // 5: down-wrap, freeze mid-count, resume
        do_reset();
        mode   = 2'b01;
        button = 1'b1;
        run_to(5);  chk("dn_e5_col", colour, 6);
                    chk("dn_e5_wrap", wrap, 1);
                    chk("dn_dir_hold", dir, 1);
        run_to(9);  chk("dn_e9_col", colour, 5);
        run_to(11);
        mode = 2'b11;
        run_to(20); chk("frz_col", colour, 5);
                    chk("frz_wrap", wrap, 0);
        mode = 2'b01;
        run_to(23); chk("dn_resume_e23", colour, 5);
        run_to(24); chk("dn_resume_e24", colour, 4);
        button = 1'b0;

        // 6: RATE=1, async reset mid-hold, restart latency
        edge_n  = -1;
        button1 = 1'b1;
        run_to(1);  chk("r1_e1", colour1, 1);
        run_to(2);  chk("r1_e2", colour1, 2);
        run_to(4);  chk("r1_e4", colour1, 4);
        #1;
        rst1 = 1'b1;
        #1;
        chk("r1_async_col", colour1, 1);
        chk("r1_async_dir", dir1, 1);
        tick();
        rst1   = 1'b0;
        edge_n = -1;
        run_to(1);  chk("r1_restart_e1", colour1, 1);
        run_to(2);  chk("r1_restart_e2", colour1, 2);
        run_to(3);  chk("r1_restart_e3", colour1, 3);
        button1 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
